// File: rtl/csa_tree_scheduler.sv
// csa_tree_scheduler: round-robin front end for one shared, free-running
// pipelined CSA adder tree. Grants one requester per cycle, registers its
// operand vector into the tree, tracks the requester tag alongside the tree
// pipeline and returns each sum tagged with its owner.
//
// Handshake: a requester transfers on a rising edge where its
// i_req_valid bit and its o_req_ready bit are both 1. o_req_ready is at
// most one-hot and never depends on a transfer having happened. Results
// have no backpressure: o_res_valid is a single-cycle pulse that the
// consumer must take.
module csa_tree_scheduler #(
    parameter int REQ_N    = 4,
    parameter int I_DATA_W = 3,
    parameter int I_DATA_N = 8,
    parameter int TREE_LAT = 4,
    parameter int O_DATA_W = 8,
    localparam int ID_W    = $clog2(REQ_N),
    localparam int VEC_W   = I_DATA_N * I_DATA_W,
    localparam int CNT_W   = $clog2(TREE_LAT + 3)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic                     i_flush,
    input  logic [REQ_N-1:0]         i_req_valid,
    input  logic [REQ_N*VEC_W-1:0]   i_req_data,
    output logic [REQ_N-1:0]         o_req_ready,
    output logic [VEC_W-1:0]         o_tree_data,
    input  logic [O_DATA_W-1:0]      i_tree_data,
    output logic                     o_res_valid,
    output logic [ID_W-1:0]          o_res_id,
    output logic [O_DATA_W-1:0]      o_res_data,
    output logic                     o_busy,
    output logic [CNT_W-1:0]         o_inflight
);

    localparam int IDX_W = ID_W + 1;

    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     next_ptr;
    logic                grant_found;
    logic                grant_ok;
    logic [IDX_W-1:0]    scan_idx;
    logic [VEC_W-1:0]    issue_vec;

    // The issue-stage tag travels with o_tree_data; the tag pipe behind it
    // lines its last stage up with i_tree_data for the same vector.
    logic                issue_valid;
    logic [ID_W-1:0]     issue_id;
    logic [TREE_LAT-1:0] tag_valid;
    logic [ID_W-1:0]     tag_id [TREE_LAT];

    logic [VEC_W-1:0]    tree_data;
    logic                res_valid;
    logic [ID_W-1:0]     res_id;
    logic [O_DATA_W-1:0] res_data;
    logic [CNT_W-1:0]    inflight;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int i = 0; i < REQ_N; i++) begin
            scan_idx = {1'b0, ptr} + IDX_W'(i);
            if (scan_idx >= IDX_W'(REQ_N)) begin
                scan_idx = scan_idx - IDX_W'(REQ_N);
            end
            if (!grant_found && i_req_valid[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    // Grant qualification, one-hot ready, next pointer and selected vector.
    always_comb begin
        grant_ok    = grant_found & i_en & ~i_flush & ~rst;
        o_req_ready = '0;
        if (grant_ok) begin
            o_req_ready[grant_id] = 1'b1;
        end
        if (grant_id == ID_W'(REQ_N - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_id + ID_W'(1);
        end
        issue_vec = i_req_data[grant_id*VEC_W +: VEC_W];
    end

    // Pointer, issue register, tag pipe and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            tree_data   <= '0;
            issue_valid <= 1'b0;
            issue_id    <= '0;
            tag_valid   <= '0;
            for (int i = 0; i < TREE_LAT; i++) begin
                tag_id[i] <= '0;
            end
            res_valid   <= 1'b0;
            res_id      <= '0;
            res_data    <= '0;
        end else begin
            if (grant_ok) begin
                ptr <= next_ptr;
            end
            // Bubbles feed zeros so the tree output for them is harmless.
            tree_data   <= grant_ok ? issue_vec : '0;
            issue_valid <= grant_ok;
            issue_id    <= grant_id;
            tag_id[0]   <= issue_id;
            for (int i = 1; i < TREE_LAT; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
            res_id <= tag_id[TREE_LAT-1];
            if (tag_valid[TREE_LAT-1]) begin
                res_data <= i_tree_data;
            end
            if (i_flush) begin
                tag_valid <= '0;
                res_valid <= 1'b0;
            end else begin
                tag_valid[0] <= issue_valid;
                for (int i = 1; i < TREE_LAT; i++) begin
                    tag_valid[i] <= tag_valid[i-1];
                end
                res_valid <= tag_valid[TREE_LAT-1];
            end
        end
    end

    // In-flight count: tag pipe stages plus the output register.
    always_comb begin
        inflight = CNT_W'(res_valid);
        for (int i = 0; i < TREE_LAT; i++) begin
            inflight = inflight + CNT_W'(tag_valid[i]);
        end
    end

    assign o_tree_data = tree_data;
    assign o_res_valid = res_valid;
    assign o_res_id    = res_id;
    assign o_res_data  = res_data;
    assign o_inflight  = inflight;
    assign o_busy      = (inflight != '0);

endmodule

// File: tb/tb_csa_tree_scheduler.sv
// Bench for csa_tree_scheduler: behavioural adder tree, a scoreboard of
// expected results keyed by due cycle, a table of arbitration vectors,
// hand-written corner sequences and a randomized run.
module tb_csa_tree_scheduler;

    localparam int REQ_N    = 4;
    localparam int I_DATA_W = 3;
    localparam int I_DATA_N = 8;
    localparam int TREE_LAT = 4;
    localparam int O_DATA_W = 8;
    localparam int ID_W     = $clog2(REQ_N);
    localparam int VEC_W    = I_DATA_N * I_DATA_W;
    localparam int CNT_W    = $clog2(TREE_LAT + 3);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     i_en;
    logic                     i_flush;
    logic [REQ_N-1:0]         i_req_valid;
    logic [REQ_N*VEC_W-1:0]   i_req_data;
    logic [REQ_N-1:0]         o_req_ready;
    logic [VEC_W-1:0]         o_tree_data;
    logic [O_DATA_W-1:0]      i_tree_data;
    logic                     o_res_valid;
    logic [ID_W-1:0]          o_res_id;
    logic [O_DATA_W-1:0]      o_res_data;
    logic                     o_busy;
    logic [CNT_W-1:0]         o_inflight;

    csa_tree_scheduler #(
        .REQ_N(REQ_N), .I_DATA_W(I_DATA_W), .I_DATA_N(I_DATA_N),
        .TREE_LAT(TREE_LAT), .O_DATA_W(O_DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_flush(i_flush),
        .i_req_valid(i_req_valid), .i_req_data(i_req_data),
        .o_req_ready(o_req_ready), .o_tree_data(o_tree_data),
        .i_tree_data(i_tree_data), .o_res_valid(o_res_valid),
        .o_res_id(o_res_id), .o_res_data(o_res_data),
        .o_busy(o_busy), .o_inflight(o_inflight)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural tree: sum of operands, TREE_LAT clocks later
    function automatic int vec_sum(input logic [VEC_W-1:0] v);
        int s;
        s = 0;
        for (int j = 0; j < I_DATA_N; j++) s += int'(v[j*I_DATA_W +: I_DATA_W]);
        return s;
    endfunction

    logic [O_DATA_W-1:0] tree_pipe [TREE_LAT];
    initial for (int i = 0; i < TREE_LAT; i++) tree_pipe[i] = '0;
    always @(posedge clk) begin
        tree_pipe[0] <= O_DATA_W'(vec_sum(o_tree_data));
        for (int i = 1; i < TREE_LAT; i++) tree_pipe[i] <= tree_pipe[i-1];
    end
    assign i_tree_data = tree_pipe[TREE_LAT-1];

    // ---------------- scoreboard ----------------
    typedef struct {
        int start;   // cycle number right after the transfer edge
        int due;     // cycle number at which the result pulse is expected
        int id;
        int sum;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int ptr_m = 0;
    int last_grant;
    int pulse_cnt;
    int pulse_data;
    int max_inflight;
    logic [REQ_N-1:0] seen_ready;
    logic [VEC_W-1:0] exp_tree = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: check the combinational grant, advance the model across
    // the edge, then check every registered output.
    task automatic cycle();
        int g;
        int n_in;
        logic [REQ_N-1:0] exp_ready;
        logic [VEC_W-1:0] slice;
        logic r, f;
        #1;
        g = -1;
        if (!rst && i_en && !i_flush) begin
            for (int off = 0; off < REQ_N; off++) begin
                if (g < 0 && i_req_valid[(ptr_m + off) % REQ_N]) g = (ptr_m + off) % REQ_N;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        seen_ready = o_req_ready;
        check("ready", o_req_ready, exp_ready);
        last_grant = g;
        slice = (g >= 0) ? i_req_data[g*VEC_W +: VEC_W] : '0;
        r = rst;
        f = i_flush;
        @(posedge clk);
        cyc++;
        if (r) begin
            exp_q.delete();
            ptr_m = 0;
            exp_tree = '0;
        end else begin
            if (f) exp_q.delete();
            exp_tree = slice;
            if (g >= 0) begin
                exp_q.push_back('{start: cyc, due: cyc + TREE_LAT + 1, id: g, sum: vec_sum(slice)});
                ptr_m = (g + 1) % REQ_N;
            end
        end
        #1;
        check("tree_data", o_tree_data, exp_tree);
        if (r) begin
            check("rst_res_id", o_res_id, 0);
            check("rst_res_data", o_res_data, 0);
        end
        n_in = 0;
        foreach (exp_q[i]) if (exp_q[i].start < cyc) n_in++;
        check("inflight", o_inflight, n_in);
        check("busy", o_busy, n_in != 0);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("res_valid", o_res_valid, 1);
            check("res_id", o_res_id, exp_q[0].id);
            check("res_data", o_res_data, exp_q[0].sum);
            void'(exp_q.pop_front());
        end else begin
            check("res_valid", o_res_valid, 0);
        end
        if (o_res_valid === 1'b1) begin
            pulse_cnt++;
            pulse_data = int'(o_res_data);
        end
        if (int'(o_inflight) > max_inflight) max_inflight = int'(o_inflight);
    endtask

    task automatic idle(input int n);
        i_req_valid = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // ---------------- arbitration table ----------------
    typedef struct {
        logic [REQ_N-1:0] valid;
        logic             en;
        logic             flush;
        logic [REQ_N-1:0] ready;
    } vec_t;
    vec_t tbl [12];

    initial begin
        // pointer starts at 0 after reset; expectations derived by hand
        tbl[0]  = '{4'b0010, 1'b1, 1'b0, 4'b0010}; // ptr 0 -> grant 1, ptr 2
        tbl[1]  = '{4'b1010, 1'b1, 1'b0, 4'b1000}; // ptr 2 -> grant 3, ptr 0
        tbl[2]  = '{4'b1010, 1'b1, 1'b0, 4'b0010}; // ptr 0 -> grant 1, ptr 2
        tbl[3]  = '{4'b1010, 1'b1, 1'b0, 4'b1000}; // ptr 2 -> grant 3, ptr 0
        tbl[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0000}; // disabled
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 4'b0000}; // flush blocks grant
        tbl[6]  = '{4'b0000, 1'b1, 1'b0, 4'b0000}; // nothing valid
        tbl[7]  = '{4'b1111, 1'b1, 1'b0, 4'b0001}; // ptr 0 held -> grant 0
        tbl[8]  = '{4'b0001, 1'b1, 1'b0, 4'b0001}; // ptr 1, wraps to 0
        tbl[9]  = '{4'b1110, 1'b1, 1'b0, 4'b0010}; // ptr 1 -> grant 1
        tbl[10] = '{4'b0011, 1'b1, 1'b0, 4'b0001}; // ptr 2, wraps to 0
        tbl[11] = '{4'b0100, 1'b1, 1'b0, 4'b0100}; // ptr 1 -> grant 2

        rst = 1'b1;
        i_en = 1'b1;
        i_flush = 1'b0;
        i_req_valid = '0;
        i_req_data = '0;
        pulse_cnt = 0;
        pulse_data = 0;
        max_inflight = 0;
        cycle();
        cycle();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            i_req_valid = tbl[i].valid;
            i_en = tbl[i].en;
            i_flush = tbl[i].flush;
            i_req_data = {$urandom, $urandom, $urandom};
            cycle();
            check("tbl_ready", seen_ready, tbl[i].ready);
        end
        i_en = 1'b1;
        i_flush = 1'b0;
        idle(7);

        // ---- single requester 2, all operands 7 -> 56 five cycles later
        do_reset();
        pulse_cnt = 0;
        i_req_data = '0;
        i_req_data[2*VEC_W +: VEC_W] = {VEC_W{1'b1}};
        i_req_valid = 4'b0100;
        cycle();
        check("single_grant", last_grant, 2);
        idle(7);
        check("single_pulses", pulse_cnt, 1);
        check("single_sum", pulse_data, 56);
        check("single_drained", o_inflight, 0);

        // ---- all requesters continuously valid, operands k+1
        do_reset();
        max_inflight = 0;
        for (int k = 0; k < REQ_N; k++)
            for (int j = 0; j < I_DATA_N; j++)
                i_req_data[(k*I_DATA_N + j)*I_DATA_W +: I_DATA_W] = I_DATA_W'(k + 1);
        i_req_valid = '1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            check("rr_seq", last_grant, i % REQ_N);
        end
        idle(7);
        check("max_inflight", max_inflight, TREE_LAT + 1);

        // ---- flush two cycles after three back-to-back transfers
        pulse_cnt = 0;
        i_req_data = {$urandom, $urandom, $urandom};
        i_req_valid = 4'b0001;
        cycle();
        cycle();
        cycle();
        idle(1);
        i_req_valid = '1;
        i_flush = 1'b1;
        cycle();
        i_flush = 1'b0;
        i_req_valid = '0;
        check("flush_busy", o_busy, 0);
        idle(1);
        check("flush_busy2", o_busy, 0);
        idle(6);
        check("flush_pulses", pulse_cnt, 0);
        i_req_valid = 4'b0010;
        cycle();
        check("post_flush_grant", last_grant, 1);
        idle(7);
        check("post_flush_pulses", pulse_cnt, 1);

        // ---- enable low with two tags in flight (pointer at 2)
        pulse_cnt = 0;
        i_req_data = {$urandom, $urandom, $urandom};
        i_req_valid = '1;
        cycle();
        cycle();
        i_en = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        check("en_pulses", pulse_cnt, 2);
        i_en = 1'b1;
        cycle();
        check("en_resume_grant", last_grant, 0);
        idle(7);

        // ---- reset with four in flight
        pulse_cnt = 0;
        i_req_valid = '1;
        for (int i = 0; i < 4; i++) cycle();
        do_reset();
        check("rst_res_valid", o_res_valid, 0);
        check("rst_tree", o_tree_data, 0);
        cycle();
        check("rst_restart_grant", last_grant, 0);
        idle(7);
        check("rst_pulses", pulse_cnt, 1);

        // ---- randomized run
        for (int i = 0; i < 400; i++) begin
            i_req_valid = REQ_N'($urandom_range(0, (1 << REQ_N) - 1));
            i_req_data = {$urandom, $urandom, $urandom};
            i_en = ($urandom_range(0, 7) != 0);
            i_flush = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;
        i_flush = 1'b0;
        i_en = 1'b1;
        idle(8);
        check("final_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/csa_tree_scheduler.md
Name: csa_tree_scheduler

Overview:
- Shares one free-running `piplined_csa_tree` instance (one operand vector per cycle, fixed latency, no stall input) between REQ_N requesters.
- Arbitrates round-robin with a valid/ready handshake and registers the winning vector into the tree.
- Carries a requester tag down a shift pipeline matched to the tree latency, and returns each sum with the owning requester id.
- Sits between the requester front-ends and the adder tree.

Parameters:
- REQ_N, 4, number of requesters (2..16).
- I_DATA_W, 3, width of one operand.
- I_DATA_N, 8, operands per vector.
- TREE_LAT, 4, tree latency in clocks from `o_tree_data` change to the matching `i_tree_data`.
- O_DATA_W, 8, tree result width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_en  in  1  grant enable; 0 = accept no new requests; in-flight work drains.
- i_flush  in  1  discard all in-flight tags.
- i_req_valid  in  REQ_N  per-requester request valid.
- i_req_data  in  REQ_N*I_DATA_N*I_DATA_W  vectors; requester k occupies slice k; operand j of k at bits [(k*I_DATA_N+j)*I_DATA_W +: I_DATA_W].
- o_req_ready  out  REQ_N  one-hot grant; transfer when valid&ready.
- o_tree_data  out  I_DATA_N*I_DATA_W  registered vector to tree `i_data`.
- i_tree_data  in  O_DATA_W  tree `o_data`.
- o_res_valid  out  1  result valid, single-cycle pulse per request.
- o_res_id  out  clog2(REQ_N)  requester owning result.
- o_res_data  out  O_DATA_W  registered sum.
- o_busy  out  1  any tag in flight (tag pipe or output register).
- o_inflight  out  clog2(TREE_LAT+3)  count of in-flight requests.

Behaviour:
- Reset values:
  - `o_req_ready` = 0 during the reset cycle.
  - `o_tree_data` = 0; all tag valids = 0; `o_res_valid` = 0.
  - `o_res_id` = 0; `o_res_data` = 0; `o_busy` = 0; `o_inflight` = 0.
  - RR pointer = 0.
- Arbitration (combinational from `i_req_valid`, pointer, `i_en`, `i_flush`, `rst`):
  - Search starts at the pointer index and wraps modulo REQ_N; the first valid index is granted.
  - `o_req_ready` is one-hot on that index, else all-zero.
  - Ready is never asserted when `i_en`=0, `i_flush`=1, `rst`=1, or no request is valid.
- Pointer update: on a transfer from requester g, pointer <= (g+1) mod REQ_N. With no transfer the pointer holds.
- Fairness: with all requesters continuously valid, the grant sequence is 0,1,...,REQ_N-1,0,... with one transfer per cycle and no idle cycles.
- Issue register:
  - On a transfer, `o_tree_data` <= selected slice; otherwise `o_tree_data` <= 0.
  - The tree sees zeros in bubbles and its output for bubbles is ignored.
- Tag pipe:
  - TREE_LAT stages of {valid, id}; stage 0 is loaded in the same cycle as the issue register.
  - Stage TREE_LAT-1 aligns with `i_tree_data` for that vector.
- Output register:
  - `o_res_valid` <= last-stage valid; `o_res_id` <= last-stage id.
  - `o_res_data` <= `i_tree_data` when last-stage valid, else holds its previous value.
- Latency: a handshake on edge E gives `o_res_valid` high after edge E+TREE_LAT+1, i.e. for one cycle, TREE_LAT+1 cycles after transfer. Fixed; results stay in issue order. There is no result backpressure: consumers must accept every pulse.
- Flush:
  - `i_flush`=1 clears all tag valids and the output valid on the next edge.
  - It blocks a grant that cycle; `o_tree_data` <= 0.
  - No `o_res_valid` occurs for any request transferred before or during the flush cycle.
  - Flush with an empty pipe is a no-op.
- `i_en`=0: ready stays low and the pointer holds; tags already issued still produce results at their scheduled cycles.
- `o_inflight` = popcount of tag valids plus output-register valid. `o_busy` = (`o_inflight` != 0).
- Reset mid-operation: identical to the reset state at the next edge; in-flight results are lost.
- Simultaneous events:
  - `rst` beats `i_flush`, which beats a grant.
  - A request that drops valid without ready is simply not granted; the pointer is unchanged.
- Width rule: the scheduler does no arithmetic on data. O_DATA_W must cover I_DATA_N*(2^I_DATA_W-1); the integrator sets it to match the tree.

Test Plan (REQ_N=4, I_DATA_W=3, I_DATA_N=8, TREE_LAT=4, behavioural tree model with latency 4):
- Reset, then only requester 2 valid with all operands=7 → ready[2]=1 on the first cycle; exactly one pulse 5 cycles later with id=2, data=56 (0x38); `o_inflight` returns to 0.
- All 4 valid continuously; requester k operands all = k+1 → grants 0,1,2,3,0,... with no gaps; results in order with data 8,16,24,32,8,...; `o_inflight` saturates at 5.
- Requesters 1 and 3 valid, pointer at 2 → grant 3 then 1 then 3; pointer wrap verified.
- Issue 3 back-to-back transfers, assert `i_flush` 2 cycles later → zero result pulses; `o_busy`=0 the next cycle; a new transfer afterwards gives a correct result at +5.
- `i_en`=0 while 2 tags are in flight with all requesters valid → ready stays 0; both results still emerge on schedule; the pointer is unchanged when `i_en` returns.
- Assert `rst` for 1 cycle with 4 in flight → all outputs zero next cycle; no stale `o_res_valid`; arbitration restarts at requester 0.
